// File: rtl/pipeline_hazard_regs.sv
// Stage registers carrying the hazard-relevant fields of the MIPS pipeline,
// plus saturating stall/flush event counters.
module pipeline_hazard_regs #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PCNextF,
  input  logic [31:0]      InstrF,
  input  logic [31:0]      PCPlus4F,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             PCSrcD,
  input  logic             FlushE,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             RegDstD,
  output logic [31:0]      PCF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic [4:0]       RsD,
  output logic [4:0]       RtD,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic [4:0]       WriteRegE,
  output logic [4:0]       WriteRegM,
  output logic [4:0]       WriteRegW,
  output logic             RegWriteE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             MemtoRegM,
  output logic             MemtoRegW,
  output logic             MemWriteE,
  output logic             MemWriteM,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [4:0] rd_d;
  logic       reg_dst_e;
  logic       stall_ev;
  logic       flush_ev;

  assign RsD  = InstrD[25:21];
  assign RtD  = InstrD[20:16];
  assign rd_d = InstrD[15:11];

  assign WriteRegE = reg_dst_e ? RdE : RtE;

  // A branch squash hidden behind a D hold is not a flush event.
  assign stall_ev = StallD;
  assign flush_ev = FlushE | (PCSrcD & ~StallD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCF <= '0;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
    end else if (StallD) begin
      InstrD   <= InstrD;
      PCPlus4D <= PCPlus4D;
    end else if (PCSrcD) begin
      InstrD   <= '0;
      PCPlus4D <= '0;
    end else begin
      InstrD   <= InstrF;
      PCPlus4D <= PCPlus4F;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      reg_dst_e <= 1'b0;
      RsE       <= '0;
      RtE       <= '0;
      RdE       <= '0;
    end else if (FlushE) begin
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      reg_dst_e <= 1'b0;
      RsE       <= '0;
      RtE       <= '0;
      RdE       <= '0;
    end else begin
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      MemWriteE <= MemWriteD;
      reg_dst_e <= RegDstD;
      RsE       <= RsD;
      RtE       <= RtD;
      RdE       <= rd_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      WriteRegM <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WriteRegW <= '0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      WriteRegM <= WriteRegE;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      WriteRegW <= WriteRegM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_ev && StallCount != CNT_MAX) begin
        StallCount <= StallCount + CNT_ONE;
      end
      if (flush_ev && FlushCount != CNT_MAX) begin
        FlushCount <= FlushCount + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/pipeline_hazard_regs.md
# pipeline_hazard_regs

Stage-register bank for the pipelined MIPS core holding every field the hazard unit reads, and the consumer of its stall and flush outputs. It holds the PC, the IF/ID instruction latch, and the hazard-relevant control and register-number fields through E, M and W. It feeds RsD/RtD/RsE/RtE, WriteRegE/M/W, RegWrite*/MemtoReg* back to the hazard unit, closing the loop. It also keeps saturating stall and flush counters for performance checks.

## Interface
- CNT_W, 16, width of the StallCount and FlushCount counters

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- PCNextF  in  32  next PC selected by fetch logic
- InstrF  in  32  instruction word read at PCF
- PCPlus4F  in  32  PCF+4
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID
- PCSrcD  in  1  taken branch in D; clears IF/ID
- FlushE  in  1  insert bubble into ID/EX
- RegWriteD, MemtoRegD, MemWriteD, RegDstD  in  1 each  decoded control for the instruction in D
- PCF  out  32  current fetch PC
- InstrD, PCPlus4D  out  32 each  IF/ID contents
- RsD, RtD  out  5 each  InstrD[25:21], InstrD[20:16]
- RsE, RtE, RdE  out  5 each  ID/EX register numbers
- WriteRegE  out  5  RegDstE ? RdE : RtE (combinational)
- WriteRegM, WriteRegW  out  5 each  destination register in M, W
- RegWriteE/M/W, MemtoRegE/M/W, MemWriteE/M  out  1 each  staged control
- StallCount, FlushCount  out  CNT_W each  saturating event counters

## Operation
- Reset (async, immediate): every register and output clears to 0, including PCF, InstrD (a nop), all control bits and the counters.
- PC register:
  - If !StallF, PCF <= PCNextF.
  - Otherwise PCF holds.
- IF/ID:
  - If StallD, InstrD and PCPlus4D hold, regardless of PCSrcD.
  - Else if PCSrcD, both clear to 0.
  - Else both load InstrF and PCPlus4F.
- RsD, RtD and RdD (InstrD[15:11]) are combinational slices of InstrD.
- ID/EX has no enable.
  - If FlushE, RegWriteE, MemtoRegE, MemWriteE, RegDstE, RsE, RtE and RdE all load 0.
  - Otherwise they load the D-stage values.
- EX/MEM and MEM/WB always load:
  - M stage: RegWriteM, MemtoRegM, MemWriteM, WriteRegM take the E-stage values.
  - W stage: RegWriteW, MemtoRegW, WriteRegW take the M-stage values.
- A bubble stays a bubble. A zero control word produces WriteReg=0 with RegWrite=0, so the hazard unit never forwards from it.
- Counters:
  - StallCount increments on each clock edge with StallD=1.
  - FlushCount increments on each edge with FlushE=1 or (PCSrcD=1 and StallD=0).
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- All state updates on the rising clk edge; reset is asynchronous.
- Register-to-output latency: one cycle per stage.
  - An instruction fetched at edge n appears in D after edge n+1, E after n+2, M after n+3, W after n+4, when there are no stalls or flushes.
- A load-use stall asserts StallF, StallD and FlushE in the same cycle. PCF and InstrD hold, and E receives a bubble. The consumer in D re-enters E one cycle later, with the load now in M.
- StallD together with PCSrcD: the hold wins and nothing is cleared. FlushCount does not increment for PCSrcD in that cycle.
- FlushE does not stop M and W from advancing.
- Reset asserted mid-operation clears every stage at once. The first PCNextF is loaded on the first edge after reset deasserts.
- Counter saturation: at the max value, an increment event leaves the count unchanged.

## Test plan
- Reset: hold reset with random inputs, then release.
  - Required: every output is 0 during reset.
  - Required: PCF = PCNextF after the first edge following release.
- Straight flow: InstrF=0x8D250004 (RsD=9, RtD=5), RegWriteD=MemtoRegD=1, RegDstD=0.
  - Required: WriteRegE=5 with RegWriteE=MemtoRegE=1 two edges after fetch.
  - Required: WriteRegM=5 on the next edge, then WriteRegW=5 on the edge after.
- Load-use stall: StallF=StallD=FlushE=1 for one cycle.
  - Required: PCF and InstrD unchanged.
  - Required: RegWriteE=MemtoRegE=0 and RsE=RtE=RdE=0.
  - Required: the prior E contents move to M.
  - Required: StallCount and FlushCount both +1.
- Taken branch: PCSrcD=1, StallD=0.
  - Required: InstrD=0 and PCPlus4D=0 next cycle.
  - Required: FlushCount +1.
- Priority: StallD=1 and PCSrcD=1 together.
  - Required: InstrD holds its previous value.
  - Required: FlushCount unchanged.
- Saturation: use CNT_W=2 and hold StallD=1 for 6 cycles.
  - Required: StallCount reads 1, 2, 3, 3, 3, 3.
  - Required: an asynchronous reset pulse between edges clears StallCount to 0 immediately.
